// File: rtl/hazard_forward_unit.sv
// Decode-stage operand hazard unit: multi-stage bypass selection, load-use
// stalls, long-latency scoreboard, outstanding-op limiter and stall stats.
module hazard_forward_unit #(
    parameter int NSTAGES = 2,
    parameter int RA_W    = 5,
    parameter int MAX_LO  = 4,
    parameter int SEL_W   = $clog2(NSTAGES + 2)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    de_valid,
    input  logic [RA_W-1:0]         de_rs1,
    input  logic [RA_W-1:0]         de_rs2,
    input  logic                    de_use_rs1,
    input  logic                    de_use_rs2,
    input  logic                    de_is_lo,
    input  logic [NSTAGES*RA_W-1:0] st_rd,
    input  logic [NSTAGES-1:0]      st_wen,
    input  logic [NSTAGES-1:0]      st_ready,
    input  logic                    lo_issue,
    input  logic [RA_W-1:0]         lo_rd,
    input  logic                    lo_done,
    input  logic [RA_W-1:0]         lo_done_rd,
    output logic [SEL_W-1:0]        forward_rs1,
    output logic [SEL_W-1:0]        forward_rs2,
    output logic                    stall,
    output logic                    lo_full,
    output logic [2**RA_W-1:0]      sb_busy,
    output logic [15:0]             stall_cycles,
    output logic                    proto_err
);

    localparam int NREGS = 2**RA_W;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LO);

    logic [NREGS-1:0] busy, busy_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             err_n;
    logic             stall_rs1, stall_rs2;

    // Resolve one source operand to {stall, select}; the youngest matching
    // stage wins and always shadows the scoreboard.
    function automatic logic [SEL_W:0] resolve(
        input logic                    use_rs,
        input logic [RA_W-1:0]         rs,
        input logic [NSTAGES*RA_W-1:0] rd,
        input logic [NSTAGES-1:0]      wen,
        input logic [NSTAGES-1:0]      rdy,
        input logic [NREGS-1:0]        bsy,
        input logic                    dn,
        input logic [RA_W-1:0]         dn_rd
    );
        logic             hit;
        logic             hit_rdy;
        logic [SEL_W-1:0] sel;
        logic             stl;
        hit     = 1'b0;
        hit_rdy = 1'b0;
        sel     = '0;
        stl     = 1'b0;
        for (int i = NSTAGES; i >= 1; i--) begin
            if (wen[i-1] && rd[i*RA_W-1 -: RA_W] == rs) begin
                hit     = 1'b1;
                hit_rdy = rdy[i-1];
                sel     = SEL_W'(i);
            end
        end
        if (!use_rs || rs == '0) begin
            sel = '0;
        end else if (hit) begin
            if (!hit_rdy) begin
                sel = '0;
                stl = 1'b1;
            end
        end else if (bsy[rs]) begin
            if (dn && dn_rd == rs) sel = SEL_W'(NSTAGES + 1);
            else stl = 1'b1;
        end
        return {stl, sel};
    endfunction

    // Operand selection and decode stall.
    always_comb begin
        {stall_rs1, forward_rs1} = resolve(de_use_rs1, de_rs1, st_rd, st_wen,
                                           st_ready, busy, lo_done, lo_done_rd);
        {stall_rs2, forward_rs2} = resolve(de_use_rs2, de_rs2, st_rd, st_wen,
                                           st_ready, busy, lo_done, lo_done_rd);
        stall = de_valid && (stall_rs1 || stall_rs2 || (de_is_lo && lo_full));
    end

    assign lo_full = (cnt == CNT_MAX);
    assign sb_busy = busy;

    // Next scoreboard, outstanding count and protocol-error detection.
    always_comb begin
        busy_n = busy;
        cnt_n  = cnt;
        err_n  = proto_err;
        if (lo_done) busy_n[lo_done_rd] = 1'b0;
        if (lo_issue && lo_rd != '0) busy_n[lo_rd] = 1'b1;
        busy_n[0] = 1'b0;
        if (lo_done && lo_done_rd != '0 && !busy[lo_done_rd]) err_n = 1'b1;
        if (lo_issue && !lo_done) begin
            if (cnt == CNT_MAX) err_n = 1'b1;
            else cnt_n = cnt + 1'b1;
        end else if (lo_done && !lo_issue) begin
            if (cnt == '0) err_n = 1'b1;
            else cnt_n = cnt - 1'b1;
        end
    end

    // State registers; reset overrides every same-cycle event.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy         <= '0;
            cnt          <= '0;
            stall_cycles <= '0;
            proto_err    <= 1'b0;
        end else begin
            busy      <= busy_n;
            cnt       <= cnt_n;
            proto_err <= err_n;
            if (stall && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: combinational vector table plus
// hand-written scoreboard, limiter and reset sequences.
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        de_valid;
    logic [4:0]  de_rs1, de_rs2;
    logic        de_use_rs1, de_use_rs2, de_is_lo;
    logic [9:0]  st_rd;
    logic [1:0]  st_wen, st_ready;
    logic        lo_issue, lo_done;
    logic [4:0]  lo_rd, lo_done_rd;
    logic [1:0]  forward_rs1, forward_rs2;
    logic        stall, lo_full, proto_err;
    logic [31:0] sb_busy;
    logic [15:0] stall_cycles;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.NSTAGES(2), .RA_W(5), .MAX_LO(4)) dut (
        .clk(clk), .reset(reset), .de_valid(de_valid),
        .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2),
        .de_is_lo(de_is_lo), .st_rd(st_rd), .st_wen(st_wen),
        .st_ready(st_ready), .lo_issue(lo_issue), .lo_rd(lo_rd),
        .lo_done(lo_done), .lo_done_rd(lo_done_rd),
        .forward_rs1(forward_rs1), .forward_rs2(forward_rs2),
        .stall(stall), .lo_full(lo_full), .sb_busy(sb_busy),
        .stall_cycles(stall_cycles), .proto_err(proto_err)
    );

    typedef struct {
        string      name;
        logic       valid;
        logic [4:0] rs1, rs2;
        logic       use1, use2, is_lo;
        logic [4:0] rd1, rd2;
        logic [1:0] wen, rdy;
        logic [1:0] f1, f2;
        logic       stl;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        de_valid = 0; de_rs1 = 0; de_rs2 = 0;
        de_use_rs1 = 0; de_use_rs2 = 0; de_is_lo = 0;
        st_rd = 0; st_wen = 0; st_ready = 0;
        lo_issue = 0; lo_rd = 0; lo_done = 0; lo_done_rd = 0;
    endtask

    task automatic issue(input logic [4:0] rd);
        lo_issue = 1; lo_rd = rd;
        tick();
        lo_issue = 0;
    endtask

    initial begin
        //       name        v  rs1 rs2 u1 u2 lo rd1 rd2 wen    rdy    f1 f2 st
        vt[0]  = '{"prio_s1",  1, 5, 0, 1, 0, 0, 5, 5, 2'b11, 2'b11, 1, 0, 0};
        vt[1]  = '{"prio_s2",  1, 5, 0, 1, 0, 0, 5, 5, 2'b10, 2'b11, 2, 0, 0};
        vt[2]  = '{"ld_use",   1, 0, 7, 0, 1, 0, 7, 0, 2'b01, 2'b00, 0, 0, 1};
        vt[3]  = '{"ld_rdy",   1, 0, 7, 0, 1, 0, 7, 0, 2'b01, 2'b01, 0, 1, 0};
        vt[4]  = '{"x0",       1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0};
        vt[5]  = '{"novalid",  0, 5, 0, 1, 0, 0, 9, 5, 2'b11, 2'b10, 2, 0, 0};
        vt[6]  = '{"both",     1, 3, 4, 1, 1, 0, 4, 3, 2'b11, 2'b11, 2, 1, 0};
        vt[7]  = '{"nowen",    1, 3, 4, 1, 1, 0, 4, 3, 2'b00, 2'b11, 0, 0, 0};
        vt[8]  = '{"young",    1, 5, 0, 1, 0, 0, 5, 5, 2'b11, 2'b10, 0, 0, 1};
        vt[9]  = '{"unused",   1, 5, 0, 0, 0, 0, 5, 0, 2'b01, 2'b00, 0, 0, 0};
        vt[10] = '{"lo_nfull", 1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0};

        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;

        foreach (vt[k]) begin
            de_valid = vt[k].valid;
            de_rs1 = vt[k].rs1; de_rs2 = vt[k].rs2;
            de_use_rs1 = vt[k].use1; de_use_rs2 = vt[k].use2;
            de_is_lo = vt[k].is_lo;
            st_rd = {vt[k].rd2, vt[k].rd1};
            st_wen = vt[k].wen; st_ready = vt[k].rdy;
            #1;
            chk({vt[k].name, ".f1"}, 32'(forward_rs1), 32'(vt[k].f1));
            chk({vt[k].name, ".f2"}, 32'(forward_rs2), 32'(vt[k].f2));
            chk({vt[k].name, ".stall"}, 32'(stall), 32'(vt[k].stl));
            tick();
        end

        idle();
        reset = 1;
        tick();
        reset = 0;
        chk("rst.busy", sb_busy, 0);
        chk("rst.full", 32'(lo_full), 0);
        chk("rst.sc", 32'(stall_cycles), 0);
        chk("rst.err", 32'(proto_err), 0);
        chk("rst.stall", 32'(stall), 0);

        de_valid = 1; de_rs2 = 7; de_use_rs2 = 1;
        st_rd = {5'd0, 5'd7}; st_wen = 2'b01; st_ready = 2'b00;
        #1;
        chk("lu.stall", 32'(stall), 1);
        tick();
        chk("lu.sc1", 32'(stall_cycles), 1);
        st_ready = 2'b01;
        #1;
        chk("lu.f2", 32'(forward_rs2), 1);
        chk("lu.nostall", 32'(stall), 0);
        tick();
        chk("lu.sc_hold", 32'(stall_cycles), 1);

        idle();
        lo_issue = 1; lo_rd = 9;
        st_rd = {5'd0, 5'd9}; st_wen = 2'b01;
        tick();
        idle();
        de_valid = 1; de_rs1 = 9; de_use_rs1 = 1;
        #1;
        chk("sb.stall", 32'(stall), 1);
        chk("sb.busy9", 32'(sb_busy[9]), 1);
        lo_done = 1; lo_done_rd = 9;
        #1;
        chk("sb.fwd", 32'(forward_rs1), 3);
        chk("sb.nostall", 32'(stall), 0);
        tick();
        idle();
        chk("sb.clr9", 32'(sb_busy[9]), 0);
        chk("sb.err", 32'(proto_err), 0);

        issue(9);
        lo_issue = 1; lo_rd = 9; lo_done = 1; lo_done_rd = 9;
        tick();
        idle();
        chk("sim.busy9", 32'(sb_busy[9]), 1);
        chk("sim.err", 32'(proto_err), 0);
        lo_done = 1; lo_done_rd = 9;
        tick();
        idle();
        chk("sim.clr9", 32'(sb_busy[9]), 0);
        chk("sim.err2", 32'(proto_err), 0);

        issue(10);
        issue(11);
        issue(12);
        chk("lim.nfull3", 32'(lo_full), 0);
        issue(13);
        chk("lim.full", 32'(lo_full), 1);
        de_valid = 1; de_is_lo = 1;
        #1;
        chk("lim.stall", 32'(stall), 1);
        de_is_lo = 0; de_rs2 = 11; de_use_rs2 = 0;
        #1;
        chk("unused_busy", 32'(stall), 0);
        de_use_rs2 = 1;
        #1;
        chk("used_busy", 32'(stall), 1);
        idle();
        chk("lim.err0", 32'(proto_err), 0);
        issue(14);
        chk("lim.err", 32'(proto_err), 1);
        chk("lim.full5", 32'(lo_full), 1);
        lo_done = 1; lo_done_rd = 10;
        tick();
        idle();
        chk("lim.cnt4", 32'(lo_full), 0);

        de_valid = 1; de_rs1 = 11; de_use_rs1 = 1;
        repeat (19) tick();
        idle();
        chk("mid.sc20", 32'(stall_cycles), 20);
        chk("mid.busy", 32'(sb_busy[13:11]), 3'b111);
        reset = 1;
        lo_issue = 1; lo_rd = 15;
        tick();
        reset = 0;
        idle();
        chk("mid.busy0", sb_busy, 0);
        chk("mid.full0", 32'(lo_full), 0);
        chk("mid.sc0", 32'(stall_cycles), 0);
        chk("mid.err0", 32'(proto_err), 0);
        lo_done = 1; lo_done_rd = 5;
        tick();
        idle();
        chk("mid.err1", 32'(proto_err), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Next-generation operand hazard block for the decode stage.
- Generalises stage-by-stage rd/rs forwarding to NSTAGES pipeline stages, with per-stage "result ready" qualification (load-use stalls).
- Adds a register scoreboard for long-latency ops (cache-miss loads, mul/div) that complete out of band.
- Produces the forward selects, the decode stall, an outstanding-op limiter, stall statistics and a protocol-error flag.

Parameters:
- NSTAGES, 2: number of downstream stages checked for forwarding; stage 1 is youngest (EX).
- RA_W, 5: register address width; the register file has 2**RA_W entries and x0 is hardwired zero.
- MAX_LO, 4: maximum outstanding long-latency ops, 1..15.
- SEL_W, $clog2(NSTAGES+2): forward select width (derived; do not override).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- de_valid  in  1  decode holds a valid instruction
- de_rs1, de_rs2  in  RA_W each  source register addresses
- de_use_rs1, de_use_rs2  in  1 each  instruction actually reads rs1 / rs2
- de_is_lo  in  1  decode instruction is a long-latency op
- st_rd  in  NSTAGES*RA_W  stage i rd at bits [i*RA_W-1 -: RA_W], i = 1..NSTAGES
- st_wen  in  NSTAGES  stage i will write rd
- st_ready  in  NSTAGES  stage i result value is available for bypass
- lo_issue  in  1  long op leaves the last tracked stage this cycle
- lo_rd  in  RA_W  destination of the issuing long op
- lo_done  in  1  long op result is on the completion bus this cycle
- lo_done_rd  in  RA_W  destination of the completing op
- forward_rs1, forward_rs2  out  SEL_W each  0 = register file, i = stage i, NSTAGES+1 = completion bus
- stall  out  1  hold decode
- lo_full  out  1  outstanding count == MAX_LO
- sb_busy  out  2**RA_W  scoreboard busy vector
- stall_cycles  out  16  saturating count of stalled cycles
- proto_err  out  1  sticky error flag

Behaviour:
- Forward and stall outputs are combinational from the inputs and the current state. State is busy[], outstanding count, stall_cycles and proto_err.
- Per source rs (evaluated only when de_use_rsN=1 and rs!=0; otherwise select=0, no stall contribution):
  - Find the lowest i with st_wen[i] && st_rd[i]==rs (youngest stage wins).
  - If such an i exists: when st_ready[i]=1, select=i; else stall.
  - Else if busy[rs]: when lo_done && lo_done_rd==rs, select=NSTAGES+1; else stall.
  - Else select=0.
- A stage match always overrides the scoreboard, because the younger write wins.
- stall = de_valid && (any rs stall || (de_is_lo && lo_full)).
- When de_valid=0, the forward selects are still computed but stall=0.
- Scoreboard update at posedge:
  - busy[lo_rd] is set on lo_issue.
  - busy[lo_done_rd] is cleared on lo_done.
  - If both events target the same register in one cycle, set wins.
  - Index 0 is never set; lo_issue with lo_rd=0 still counts toward outstanding.
  - busy set by lo_issue becomes visible on the following cycle. In the issue cycle the op is still covered by its stage entry (st_wen=1, st_ready=0).
- Outstanding count: +1 on lo_issue, -1 on lo_done, unchanged if both occur. lo_full = (count==MAX_LO).
- proto_err is set, and stays set until reset, when any of these occur:
  - lo_done while count==0 without a same-cycle lo_issue;
  - lo_done to a register with busy=0 (x0 excepted);
  - lo_issue while count==MAX_LO without a same-cycle lo_done.
- An illegal increment or decrement leaves the count unchanged.
- stall_cycles increments each cycle stall=1 and saturates at 16'hFFFF.
- Reset (synchronous, wins over all same-cycle events): busy=0, count=0, lo_full=0, stall_cycles=0, proto_err=0. Resulting combinational outputs are forward=0 and stall=0 unless stage inputs match.
- Flushes are handled upstream by deasserting st_wen/de_valid. Issued long ops are committed and are not cancelled by this block.

Test Plan:
- Stage priority: NSTAGES=2, rs1=5, st_rd={5,5}, st_wen=11, st_ready=11 -> forward_rs1=1, stall=0. With st_wen=10 -> forward_rs1=2.
- Load-use: st_rd[1]=7, st_wen[1]=1, st_ready[1]=0, rs2=7, de_valid=1 -> stall=1, stall_cycles increments. With st_ready[1]=1 next cycle -> forward_rs2=1, stall=0.
- x0 and unused operands:
  - rs1=0 matching stage 1 with st_ready=0 -> forward_rs1=0, stall=0.
  - de_use_rs2=0 with a matching busy rs2 -> no stall.
- Scoreboard:
  - lo_issue rd=9; next cycle rs1=9 -> stall=1, sb_busy[9]=1.
  - lo_done rd=9 that cycle -> forward_rs1=3, stall=0; the following cycle sb_busy[9]=0.
  - Simultaneous issue and done on rd=9 -> busy stays 1.
- Limiter: MAX_LO=4, issue 4 ops -> lo_full=1; de_is_lo=1 -> stall=1. A 5th lo_issue -> proto_err=1, count stays 4.
- Reset mid-operation: three busy regs, stall_cycles=20, proto_err=1, assert reset for 1 cycle -> all busy=0, count=0, stall_cycles=0, proto_err=0. A subsequent lo_done -> proto_err=1.
